// File: rtl/i2c_codec_responder.sv
// I2C slave standing in for the audio codec control port: decodes 3-byte write
// frames {addr+W, reg[6:0]|data[8], data[7:0]}, ACKs each byte and commits 9-bit words.
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_valid,
    output logic [6:0] wr_reg,
    output logic [8:0] wr_data,
    output logic       err_nack,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK_A  = 3'd2,
        BYTE1  = 3'd3,
        ACK_1  = 3'd4,
        BYTE2  = 3'd5,
        ACK_2  = 3'd6,
        IGNORE = 3'd7
    } state_t;

    logic       scl_meta_r, scl_sync_r, scl_prev_r;
    logic       sda_meta_r, sda_sync_r, sda_prev_r;
    logic       scl_rise_s, scl_fall_s, scl_edge_s, start_s, stop_s;

    state_t     state_r, state_next_s;
    logic [3:0] cnt_r, cnt_next_s;
    logic [6:0] shift_r, shift_next_s;
    logic [7:0] byte_s;
    logic       sda_oe_r, sda_oe_next_s;
    logic       extra_r, extra_next_s;
    logic [6:0] reg_lat_r, reg_lat_next_s;
    logic       data8_r, data8_next_s;
    logic [7:0] data_lo_r, data_lo_next_s;
    logic       commit_r, commit_next_s;
    logic       nack_next_s;
    logic       err_nack_r, busy_r, wr_valid_r;
    logic [6:0] wr_reg_r;
    logic [8:0] wr_data_r, rd_data_r, rd_next_s, commit_data_s;
    logic [8:0] regs_r [NUM_REGS];

    // Two-flop synchronizers plus a history flop on both bus lines
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // An scl edge in the same cycle masks START/STOP decoding
    assign scl_rise_s    = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s    = ~scl_sync_r & scl_prev_r;
    assign scl_edge_s    = scl_sync_r ^ scl_prev_r;
    assign start_s       = ~scl_edge_s & scl_sync_r & ~sda_sync_r & sda_prev_r;
    assign stop_s        = ~scl_edge_s & scl_sync_r & sda_sync_r & ~sda_prev_r;
    assign byte_s        = {shift_r, sda_sync_r};
    assign commit_data_s = {data8_r, data_lo_r};

    // Frame FSM next-state and datapath decode
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        shift_next_s   = shift_r;
        sda_oe_next_s  = sda_oe_r;
        extra_next_s   = extra_r;
        reg_lat_next_s = reg_lat_r;
        data8_next_s   = data8_r;
        data_lo_next_s = data_lo_r;
        commit_next_s  = 1'b0;
        nack_next_s    = 1'b0;
        if (start_s) begin
            state_next_s  = ADDR;
            cnt_next_s    = 4'd0;
            sda_oe_next_s = 1'b0;
            extra_next_s  = 1'b0;
        end else if (stop_s) begin
            state_next_s  = IDLE;
            cnt_next_s    = 4'd0;
            sda_oe_next_s = 1'b0;
            extra_next_s  = 1'b0;
        end else begin
            case (state_r)
                ADDR, BYTE1, BYTE2: begin
                    if (scl_rise_s) begin
                        shift_next_s = byte_s[6:0];
                        if (cnt_r == 4'd7) begin
                            cnt_next_s = 4'd0;
                            case (state_r)
                                ADDR: begin
                                    if (byte_s == {DEV_ADDR, 1'b0}) begin
                                        state_next_s = ACK_A;
                                    end else begin
                                        state_next_s = IGNORE;
                                        nack_next_s  = 1'b1;
                                    end
                                end
                                BYTE1: begin
                                    reg_lat_next_s = byte_s[7:1];
                                    data8_next_s   = byte_s[0];
                                    state_next_s   = ACK_1;
                                end
                                default: begin
                                    data_lo_next_s = byte_s;
                                    commit_next_s  = 1'b1;
                                    state_next_s   = ACK_2;
                                end
                            endcase
                        end else begin
                            cnt_next_s = cnt_r + 4'd1;
                        end
                    end else begin
                        shift_next_s = shift_r;
                    end
                end
                ACK_A, ACK_1, ACK_2: begin
                    // First scl fall grabs sda, the one after the 9th clock lets go
                    if (scl_fall_s) begin
                        if (!sda_oe_r) begin
                            sda_oe_next_s = 1'b1;
                        end else begin
                            sda_oe_next_s = 1'b0;
                            case (state_r)
                                ACK_A:   state_next_s = BYTE1;
                                ACK_1:   state_next_s = BYTE2;
                                default: begin
                                    state_next_s = IGNORE;
                                    extra_next_s = 1'b1;
                                end
                            endcase
                        end
                    end else begin
                        sda_oe_next_s = sda_oe_r;
                    end
                end
                IGNORE: begin
                    // Count 9-clock byte slots; surplus bytes after a frame are NACKed
                    if (scl_rise_s) begin
                        cnt_next_s  = (cnt_r == 4'd8) ? 4'd0 : cnt_r + 4'd1;
                        nack_next_s = extra_r & (cnt_r == 4'd7);
                    end else begin
                        cnt_next_s = cnt_r;
                    end
                end
                default: begin
                    state_next_s = state_r;
                end
            endcase
        end
    end

    // FSM state and frame datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            shift_r    <= 7'd0;
            sda_oe_r   <= 1'b0;
            extra_r    <= 1'b0;
            reg_lat_r  <= 7'd0;
            data8_r    <= 1'b0;
            data_lo_r  <= 8'd0;
            commit_r   <= 1'b0;
            err_nack_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            shift_r    <= shift_next_s;
            sda_oe_r   <= sda_oe_next_s;
            extra_r    <= extra_next_s;
            reg_lat_r  <= reg_lat_next_s;
            data8_r    <= data8_next_s;
            data_lo_r  <= data_lo_next_s;
            commit_r   <= commit_next_s;
            err_nack_r <= nack_next_s;
            busy_r     <= (state_next_s != IDLE);
        end
    end

    // Register file commit and write-event outputs; index 15 doubles as a clear-all
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 9'd0;
            end
            wr_valid_r <= 1'b0;
            wr_reg_r   <= 7'd0;
            wr_data_r  <= 9'd0;
        end else begin
            wr_valid_r <= commit_r;
            if (commit_r) begin
                if (reg_lat_r[3:0] == 4'hF) begin
                    for (int i = 0; i < NUM_REGS - 1; i++) begin
                        regs_r[i] <= 9'd0;
                    end
                end
                regs_r[reg_lat_r[3:0]] <= commit_data_s;
                wr_reg_r  <= reg_lat_r;
                wr_data_r <= commit_data_s;
            end
        end
    end

    // Read-port value with bypass of a commit landing in the same cycle
    always_comb begin
        rd_next_s = regs_r[rd_addr];
        if (commit_r) begin
            if (reg_lat_r[3:0] == rd_addr) begin
                rd_next_s = commit_data_s;
            end else if (reg_lat_r[3:0] == 4'hF) begin
                rd_next_s = 9'd0;
            end else begin
                rd_next_s = regs_r[rd_addr];
            end
        end else begin
            rd_next_s = regs_r[rd_addr];
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= 9'd0;
        end else begin
            rd_data_r <= rd_next_s;
        end
    end

    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign rd_data  = rd_data_r;
    assign wr_valid = wr_valid_r;
    assign wr_reg   = wr_reg_r;
    assign wr_data  = wr_data_r;
    assign err_nack = err_nack_r;
    assign busy     = busy_r;

endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
- Single-clock I2C slave that models the audio codec's 2-wire control port; the other end of the codec configuration master.
- Decodes START/STOP and the 3-byte codec write frame {address+W, reg[6:0] & data[8], data[7:0]}, ACKs each byte and commits 9-bit words into a register file.
- Used as the bus partner in master benches and as an on-chip loopback target.
- Exposes write events and a read-back port for checking configuration.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit slave address answered; write byte 0x34.
- NUM_REGS, 16, register file depth; register index is reg[3:0], reg[6:4] ignored.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scl  input  1  I2C clock from master (master-driven only, no clock stretching)
- sda  inout  1  I2C data, open-drain: driven 0 when sda_oe=1, else 1'bz
- rd_addr  input  4  register file read index
- rd_data  output  9  register contents at rd_addr, registered (1-cycle latency)
- wr_valid  output  1  one-cycle pulse when a complete frame commits
- wr_reg  output  7  register index of last committed frame
- wr_data  output  9  data of last committed frame
- err_nack  output  1  one-cycle pulse on address mismatch, R/W=1, or an extra byte
- busy  output  1  high from START to STOP

Behaviour:
- Reset values: sda_oe=0 (sda released), wr_valid=0, wr_reg=0, wr_data=0, err_nack=0, busy=0, rd_data=0, all registers 0, state IDLE, bit counter 0.
- Reset mid-frame aborts at once, releases sda, and does not commit a write.
- Input conditioning:
  - scl and sda each pass through a 2-flop synchronizer plus a history flop.
  - Edges are detected on the synchronized signals, so each event lags the pin by 3 clk.
  - Timing requirement on the master: scl high/low ≥ 4 clk each; sda changes ≥ 3 clk away from scl edges.
- START: sda falls while scl is high → state ADDR, bit counter 0, busy=1. Accepted in any state (repeated START restarts the frame and drops any partial frame).
- STOP: sda rises while scl is high → IDLE, busy=0, sda released. A partial frame is discarded.
- Data bits are sampled on the scl rising edge, MSB first; the shift register is 8 bits.
- States: IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE.
- ADDR, on the 8th rising edge:
  - If addr==DEV_ADDR and R/W=0, go to ACK_A.
  - Otherwise pulse err_nack and go to IGNORE; sda is never driven.
- ACK states:
  - On the scl falling edge after the 8th bit, set sda_oe=1.
  - On the next scl falling edge (after the 9th clock), set sda_oe=0 and advance: ACK_A→BYTE1, ACK_1→BYTE2, ACK_2→IGNORE.
- BYTE1: on the 8th bit, latch reg=byte[7:1] and data[8]=byte[0], then go to ACK_1.
- BYTE2: on the 8th bit, latch data[7:0].
  - The cycle after the sampling edge is detected, update the register file, load wr_reg/wr_data, and pulse wr_valid for 1 clk.
  - Then go to ACK_2.
- IGNORE:
  - Never drives sda and counts bytes.
  - After an ACK_2, every further complete byte is not ACKed and pulses err_nack once per byte.
  - Leaves only on START or STOP.
- Reset register: a frame committing reg[3:0]==4'hF clears regs 0..14 to 0, stores the data in reg 15, and still pulses wr_valid.
- rd_data updates one cycle after rd_addr changes. If a commit and a read of the same index occur in the same cycle, rd_data returns the new value.
- Simultaneous scl and sda edges in one cycle: the scl edge takes priority and START/STOP is not decoded.

Test Plan:
- Frame 0x34, 0x0E, 0x4A, then STOP → sda low on all three 9th clocks; wr_valid pulses once; wr_reg=7, wr_data=9'h04A; rd_addr=7 gives rd_data=9'h04A.
- Frame 0x34, 0x09, 0x7F → reg 4 = 9'h17F (data[8] taken from byte1 bit 0); then frame 0x34, 0x1E, 0x00 → regs 0..14 read 0, reg 15 = 0, wr_valid pulses.
- Address byte 0x36, then 0x35 (read bit) → sda stays high on the 9th clock; err_nack pulses once per frame; no wr_valid; registers unchanged.
- START, 0x34, 0x0E, then STOP → only the address and byte1 are ACKed; no wr_valid; reg 7 keeps its prior value. Repeated START mid-BYTE2 followed by a full frame → exactly one commit, from the second frame.
- Valid frame plus a 4th byte 0xAA → no ACK on the 4th byte; err_nack pulses once; exactly one wr_valid.
- Reset asserted while sda_oe=1 during ACK_1 → sda released the next clk, busy=0, no commit; the next full frame works normally.
